// File: rtl/demuxer16_collect.sv
// Serial-to-parallel 1:WIDTH demultiplexer with a one-word valid/ready output buffer.
// Optional DEMUX_MSB_FIRST_EN: first accepted bit lands in q[WIDTH-1] and sel counts down.
module demuxer16_collect #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready
);

`ifdef DEMUX_MSB_FIRST_EN
  localparam logic [IDX_W-1:0] Start = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] End   = '0;
`else
  localparam logic [IDX_W-1:0] Start = '0;
  localparam logic [IDX_W-1:0] End   = IDX_W'(WIDTH - 1);
`endif

  typedef enum logic [0:0] {StCollect, StFull} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   collector_q, collector_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_valid_q, q_valid_d;
  logic [WIDTH-1:0]   word_new;
  logic               accept;

  assign in_ready = (state_q == StCollect);
  assign sel      = sel_q;
  assign q        = q_q;
  assign q_valid  = q_valid_q;

  // clear wins over an offered bit and over a stalled-word transfer
  assign accept = in_valid && in_ready && !clear;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    collector_d = collector_q;
    q_d         = q_q;
    q_valid_d   = q_valid_q;
    word_new    = collector_q;
    word_new[sel_q] = in_bit;

    if (q_valid_q && q_ready) q_valid_d = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (sel_q == End) begin
            sel_d = Start;
            if (!q_valid_q || q_ready) begin
              q_d         = word_new;
              q_valid_d   = 1'b1;
              collector_d = '0;
            end else begin
              collector_d = word_new;
              state_d     = StFull;
            end
          end else begin
            collector_d = word_new;
`ifdef DEMUX_MSB_FIRST_EN
            sel_d = sel_q - IDX_W'(1);
`else
            sel_d = sel_q + IDX_W'(1);
`endif
          end
        end
      end
      StFull: begin
        if (q_ready && !clear) begin
          q_d         = collector_q;
          q_valid_d   = 1'b1;
          collector_d = '0;
          state_d     = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase

    if (clear) begin
      collector_d = '0;
      sel_d       = Start;
      state_d     = StCollect;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      sel_q       <= Start;
      collector_q <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      collector_q <= collector_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
    end
  end

endmodule

// File: tb/tb_demuxer16_collect.sv
// Scoreboard bench for demuxer16_collect: words are queued as sent, a monitor checks each
// q handshake against the queue, and directed checks cover timing and boundary cases.
module tb_demuxer16_collect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  sel;
  logic [15:0] q;
  logic        q_valid;
  logic        q_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

`ifdef DEMUX_MSB_FIRST_EN
  localparam logic [3:0] Start = 4'd15;
`else
  localparam logic [3:0] Start = 4'd0;
`endif

  demuxer16_collect dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready)
  );

  always #5 clk = ~clk;

  // Word as it lands in q when bits are sent in w[0]..w[15] order
  function automatic logic [15:0] exp_of(input logic [15:0] w);
    logic [15:0] r;
`ifdef DEMUX_MSB_FIRST_EN
    for (int i = 0; i < 16; i++) r[15-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_bit   = b;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    exp_q.push_back(exp_of(w));
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  // Monitor: a handshake completes at the next posedge, so sample on the negedge before it
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && q_valid && q_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(q), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard_q", 32'(q), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    #12;
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_valid", 32'(q_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_sel", 32'(sel), 32'(Start));
    rst_n = 1'b1;
    tick();

    // 1: reset mid-word discards the partial word
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    check("midrst_q", 32'(q), 32'h0);
    check("midrst_q_valid", 32'(q_valid), 32'h0);
    check("midrst_sel", 32'(sel), 32'(Start));
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    tick();
    send_word(16'hC3A1);
    check("fresh_word", 32'(q), 32'(exp_of(16'hC3A1)));

    // 2: one-hot and inverse patterns; q_valid one cycle after the 16th bit
    for (int k = 0; k < 16; k++) begin
      w = 16'h1 << k;
      send_word(w);
      check("onehot_valid", 32'(q_valid), 32'h1);
      check("onehot_q", 32'(q), 32'(exp_of(w)));
      send_word(~w);
      check("inverse_q", 32'(q), 32'(exp_of(~w)));
    end
    tick();
    check("idle_q_valid", 32'(q_valid), 32'h0);

    // 3: backpressure fills the buffer, then drains with no bubble
    q_ready = 1'b0;
    send_word(16'hA5A5);
    send_word(16'h5A5A);
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_q_held", 32'(q), 32'(exp_of(16'hA5A5)));
    q_ready = 1'b1;
    tick();
    check("drain_q", 32'(q), 32'(exp_of(16'h5A5A)));
    check("drain_q_valid", 32'(q_valid), 32'h1);
    check("drain_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("drained_q_valid", 32'(q_valid), 32'h0);

    // 4: clear aborts a partial word and drops the bit offered with it
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_sel", 32'(sel), 32'(Start));
    check("clear_q_valid", 32'(q_valid), 32'h0);
    send_word(16'h1234);
    check("after_clear_q", 32'(q), 32'(exp_of(16'h1234)));

    // 5: serial 1 then fifteen 0s
    send_word(16'h0001);
`ifdef DEMUX_MSB_FIRST_EN
    check("first_bit_pos", 32'(q), 32'h8000);
`else
    check("first_bit_pos", 32'(q), 32'h0001);
`endif

    // 6: q consumed in the same cycle the next word's last bit arrives
    tick();
    q_ready = 1'b0;
    send_word(16'h1111);
    w = 16'hBEEF;
    exp_q.push_back(exp_of(w));
    for (int i = 0; i < 15; i++) send_bit(w[i]);
    q_ready = 1'b1;
    send_bit(w[15]);
    check("nobubble_q_valid", 32'(q_valid), 32'h1);
    check("nobubble_q", 32'(q), 32'(exp_of(16'hBEEF)));
    tick();
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
